logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares a single WIDTH-bit bitwise logic unit (AND, OR, NOT, NAND, NOR, XOR, XNOR) among NREQ requesters. Requests are granted round-robin, one at a time. Each granted operation is executed and its registered result is returned with the winner's ID under a valid/ready handshake. The block sits between several client blocks and the gate-level datapath, so the datapath is instantiated once rather than per client.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); ID width IDW = clog2(NREQ).
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NREQ  bit i = requester i has an operation pending.
- req_ready  out  NREQ  one-hot grant/accept strobe, high for one cycle.
- req_op  in  3*NREQ  opcode, slice i = requester i.
- req_a  in  WIDTH*NREQ  operand A, slice i = requester i.
- req_b  in  WIDTH*NREQ  operand B, slice i = requester i; ignored for NOT.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_y  out  WIDTH  result.
- rsp_err  out  1  the opcode was illegal.
- busy  out  1  high in every state except IDLE.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT (y = ~a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal. An illegal opcode returns y = 0 with rsp_err = 1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit scanning upward from the round-robin pointer `ptr`, wrapping modulo NREQ.
  - Drive req_ready for the winner combinationally in that cycle.
  - Latch the winner's op, a, b and ID, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC: register the logic-unit output into rsp_y and rsp_err, then go to RESP.
- RESP:
  - Hold rsp_valid = 1 with rsp_id, rsp_y and rsp_err stable.
  - When rsp_valid and rsp_ready are both high, go to IDLE and set ptr = (winner + 1) mod NREQ.
- req_ready is zero in every state except IDLE and is at most one-hot.
- A requester must hold req_valid and its operands until it sees its req_ready. req_valid may drop without a grant; no request is ever lost or duplicated.
- Requests arriving while the block is busy wait; there is no queueing.
- Reset values:
  - State IDLE, ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, rsp_err = 0, busy = 0.
- Reset asserted mid-operation aborts the operation: no response is produced, and the latched request is discarded.

## Timing
- The grant occurs in cycle N (req_ready high). rsp_valid rises in cycle N+2.
- If rsp_ready is already high, the response completes in N+2, the block is back in IDLE at N+3, and the next grant occurs at N+3. Peak throughput is one operation per 3 cycles.
- Backpressure: RESP holds indefinitely while rsp_ready = 0. No new grant is issued during that time.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,…,NREQ-1,0. Each requester is served within NREQ operations of raising req_valid.
- Simultaneous new request and response handshake in RESP: the new request is considered in the following IDLE cycle, using the updated ptr.
- busy is registered from state and is high for EXEC and RESP.

## Structure
- Shared package logic_ops_pkg holds the opcode constants (OP_AND … OP_XNOR, OP_ILL = 7) and the state encoding (IDLE, EXEC, RESP).
- Sub-module logic_unit: purely combinational, parameter WIDTH, inputs op, a and b, outputs y and err. It is built from the team's existing bitwise gate functions, and the arbiter instantiates it once.
- The round-robin pick is a function or always block inside logic_unit_arbiter; it is not a separate module.

## Test plan
- Single request: WIDTH=8, requester 2 sends op=0 (AND), a=8'hF0, b=8'h3C.
  - Required: req_ready[2] in cycle N; rsp_valid at N+2 with rsp_y=8'h30, rsp_id=2, rsp_err=0.
- All opcodes: a=8'hA5, b=8'h0F for op 0..7.
  - Required rsp_y: op0 05, op1 AF, op2 5A, op3 FA, op4 50, op5 AA, op6 55, op7 00 with rsp_err=1.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1.
  - Required grant order 0,1,2,3,0, one grant every 3 cycles. Then drop requester 1: order continues 2,3,0,2.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_valid, rsp_y and rsp_id remain stable, req_ready stays 0, and a single response completes when rsp_ready rises.
- Reset mid-operation: assert rst in EXEC.
  - Required: all outputs 0 asynchronously and no rsp_valid afterwards. The next request is granted starting from ptr=0.

Source files
------------

// File: rtl/logic_ops_pkg.sv
// Purpose: shared opcodes, arbiter state encoding and bitwise gate helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package logic_ops_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Gate helpers operate on the widest supported operand; callers
    // zero-extend their inputs and keep only the low bits of the result.
    localparam int GATE_W = 64;
    typedef logic [GATE_W-1:0] gate_word_t;

    function automatic gate_word_t gate_and(input gate_word_t a, input gate_word_t b);
        return a & b;
    endfunction

    function automatic gate_word_t gate_or(input gate_word_t a, input gate_word_t b);
        return a | b;
    endfunction

    function automatic gate_word_t gate_not(input gate_word_t a);
        return ~a;
    endfunction

    function automatic gate_word_t gate_xor(input gate_word_t a, input gate_word_t b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/logic_unit.sv
// Purpose: combinational WIDTH-bit bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; ports op, a, b in and y, err out (err=1 and y=0 for opcode 7).
module logic_unit
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    gate_word_t ax;
    gate_word_t bx;
    gate_word_t r;

    assign ax = GATE_W'(a);
    assign bx = GATE_W'(b);

    always_comb begin
        r   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  r = gate_and(ax, bx);
            OP_OR:   r = gate_or(ax, bx);
            OP_NOT:  r = gate_not(ax);
            OP_NAND: r = gate_not(gate_and(ax, bx));
            OP_NOR:  r = gate_not(gate_or(ax, bx));
            OP_XOR:  r = gate_xor(ax, bx);
            OP_XNOR: r = gate_not(gate_xor(ax, bx));
            default: err = 1'b1;
        endcase
    end

    assign y = r[WIDTH-1:0];

endmodule

// File: rtl/logic_unit_arbiter.sv
// Purpose: round-robin share of one logic_unit among NREQ requesters.
// Latency: grant in cycle N, registered result valid in N+2; one op per 3 cycles peak.
// Backpressure: RESP holds while rsp_ready=0, no new grant meanwhile.
// Ports: req_valid/req_ready/req_op/req_a/req_b per requester (sliced), rsp_valid/rsp_ready/
//        rsp_id/rsp_y/rsp_err towards the consumer, busy high outside IDLE.
module logic_unit_arbiter
    import logic_ops_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic             busy_q;

    logic [WIDTH-1:0] lu_y;
    logic             lu_err;

    logic             pick_vld;
    int               pick_i;
    int               scan_i;
    logic [NREQ-1:0]  grant_vec;

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (lu_y),
        .err (lu_err)
    );

    // Scan downward from ptr+NREQ-1 to ptr so the last hit, which wins,
    // is the first valid requester at or after ptr (modulo NREQ).
    always_comb begin
        pick_vld = 1'b0;
        pick_i   = 0;
        scan_i   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_i = (int'(ptr_q) + k) % NREQ;
            if (req_valid[scan_i]) begin
                pick_vld = 1'b1;
                pick_i   = scan_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        y_d       = y_q;
        err_d     = err_q;
        grant_vec = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_vec[pick_i] = 1'b1;
                    id_d    = IDW'(pick_i);
                    op_d    = req_op[pick_i*3 +: 3];
                    a_d     = req_a[pick_i*WIDTH +: WIDTH];
                    b_d     = req_b[pick_i*WIDTH +: WIDTH];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d     = lu_y;
                err_d   = lu_err;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // The grant is combinational from req_valid; mask it while reset is held
    // so a requester never sees an accept that the FSM cannot honour.
    assign req_ready = grant_vec & {NREQ{~rst}};
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_err;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[r*3 +: 3]       = op;
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
    endtask

    // One isolated operation from requester r; checks grant, N+1 quiet, N+2 result.
    task automatic run_op(input int r, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] ey, input logic ee,
                          input string tag);
        int n;
        set_req(r, op, a, b);
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk({tag, "_gnt"}, 32'(req_ready), 32'(1 << r));
        step();
        req_valid[r] = 1'b0;
        #1;
        chk({tag, "_n1_vld"}, 32'(rsp_valid), 32'd0);
        step();
        #1;
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_y"},   32'(rsp_y),     32'(ey));
        chk({tag, "_id"},  32'(rsp_id),    32'(r));
        chk({tag, "_err"}, 32'(rsp_err),   32'(ee));
        step();
    endtask

    logic [7:0] exp_y [8];
    int         order [9];

    initial begin
        exp_y = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
        order = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_vld",   32'(rsp_valid), 32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_y",     32'(rsp_y),     32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        step();
        rst = 1'b0;

        // Single request from requester 2.
        run_op(2, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, "single");

        // Every opcode; requester rotates so the last one (3) leaves ptr at 0.
        for (int op = 0; op < 8; op++) begin
            run_op(op % 4, 3'(op), 8'hA5, 8'h0F, exp_y[op], (op == 7), $sformatf("op%0d", op));
        end

        // Round-robin with all requesters valid, then requester 1 drops out.
        for (int r = 0; r < NREQ; r++) set_req(r, 3'd5, 8'(r), 8'hFF);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 27; c++) begin
            if (c == 15) req_valid = 4'b1101;
            #1;
            chk($sformatf("rr_gnt_c%0d", c), 32'(req_ready),
                (c % 3 == 0) ? 32'(1 << order[c / 3]) : 32'd0);
            if (c % 3 == 2) begin
                chk($sformatf("rr_id_c%0d", c), 32'(rsp_id), 32'(order[c / 3]));
                chk($sformatf("rr_y_c%0d", c), 32'(rsp_y), 32'(~order[c / 3] & 8'hFF));
            end
            step();
        end
        req_valid = '0;

        // Backpressure: ptr is 3, only requester 1 valid.
        rsp_ready = 1'b0;
        set_req(1, 3'd5, 8'h3C, 8'hFF);
        req_valid = 4'b0010;
        #1;
        chk("bp_gnt", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1101;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_vld_%0d", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_y_%0d", c),   32'(rsp_y),     32'hC3);
            chk($sformatf("bp_id_%0d", c),  32'(rsp_id),    32'd1);
            chk($sformatf("bp_rdy_%0d", c), 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_last_vld", 32'(rsp_valid), 32'd1);
        step();
        #1;
        chk("bp_done_vld", 32'(rsp_valid), 32'd0);
        chk("bp_next_gnt", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b1001;

        // Reset while requester 2's operation is in EXEC.
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_ready", 32'(req_ready), 32'd0);
        chk("mr_vld",   32'(rsp_valid), 32'd0);
        chk("mr_id",    32'(rsp_id),    32'd0);
        chk("mr_y",     32'(rsp_y),     32'd0);
        chk("mr_err",   32'(rsp_err),   32'd0);
        chk("mr_busy",  32'(busy),      32'd0);
        step();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mr_quiet_%0d", c), 32'(rsp_valid), 32'd0);
            step();
        end
        // From ptr=0 requester 1 wins over 3; a stale ptr of 2 would pick 3.
        req_valid = 4'b1010;
        #1;
        chk("mr_ptr_gnt", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        #1;
        chk("mr_rsp_id", 32'(rsp_id), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
